fetch_queue: RTL

- Instruction fetch queue directly downstream of the 12-bit PC register and instruction memory.
- Captures each fetched {PC, instruction} pair and presents it in order to decode over a valid/ready handshake.
- Decouples fetch from decode stalls, and discards all queued entries on a branch/jump flush.

---
 rtl/fetch_queue.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {PC, instruction} queue between instruction fetch and decode.
// The queue holds up to DEPTH entries and is emptied on a branch/jump flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// entry is presented to decode combinationally and, if decode accepts it in
// the same cycle, it is never written to storage.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 3,
  parameter int PC_W   = 12,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INSN_W-1:0] out_insn,
  output logic [CNT_W-1:0]  count
);

  localparam int ENT_W = PC_W + INSN_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // Handshake decode and head-of-queue selection; outputs forced to zero when empty.
  always_comb begin
    empty     = (count == '0);
    in_ready  = (count != CNT_W'(DEPTH));
    head      = empty ? '0 : mem[rd_ptr];
    pop       = ~empty & out_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch entry directly; it is stored only
    // if decode is not taking it this cycle.
    out_valid = ~empty | in_valid;
    if (empty && in_valid) begin
      head = {in_pc, in_insn};
    end
    push      = in_valid & in_ready & ~(empty & out_ready);
`else
    out_valid = ~empty;
    push      = in_valid & in_ready;
`endif
    out_pc    = head[ENT_W-1 -: PC_W];
    out_insn  = head[INSN_W-1:0];
  end

  // Entry storage; not reset, since stale slots are never presented while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_pc, in_insn};
    end
  end

  // Pointer and occupancy control: clr, then flush, then push/pop.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
